// File: rtl/ttt_pkg.sv
// Shared constants, win-line table and coordinate decode for the tic-tac-toe core.
package ttt_pkg;

  localparam int unsigned CELLS = 9;
  localparam int unsigned LINES = 8;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_XWIN = 2'b01;
  localparam logic [1:0] GS_OWIN = 2'b10;
  localparam logic [1:0] GS_DRAW = 2'b11;

  localparam logic SYM_X = 1'b1;
  localparam logic SYM_O = 1'b0;

  localparam logic [3:0] IDX_NONE = 4'hF;

  // Cell indices of the eight winning lines: rows, columns, diagonals.
  localparam logic [3:0] WIN_LINE [LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Map (row, col) to a cell index; coordinate 3 selects nothing.
  function automatic logic [3:0] rc_to_index(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd3 || col == 2'd3) return IDX_NONE;
    return 4'(4'(row) * 4'd3) + 4'(col);
  endfunction

endpackage

// File: rtl/ttt_cell.sv
// One write-once board cell: first set after reset captures the owner.
module ttt_cell (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic set_symbol,
  output logic valid,
  output logic symbol
);

  // Capture owner on the first set; later sets are ignored until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      symbol <= 1'b0;
    end else if (set && !valid) begin
      valid  <= 1'b1;
      symbol <= set_symbol;
    end
  end

endmodule

// File: rtl/ttt_board.sv
// Tic-tac-toe game core: move decode/acceptance, board, turn and win/draw state.
module ttt_board
  import ttt_pkg::*;
#(
  parameter logic X_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [8:0] valid,
  output logic [8:0] symbol,
  output logic [1:0] game_state,
  output logic       turn,
  output logic       move_err
);

  logic [3:0] idx_c;
  logic [8:0] sel_c;
  logic [8:0] next_valid_c;
  logic [8:0] next_symbol_c;
  logic       accept_c;
  logic       won_c;
  logic [1:0] eval_c;

  // Decode the request, decide acceptance and score the board as it will be after this edge.
  always_comb begin
    idx_c         = rc_to_index(row, col);
    sel_c         = (idx_c == IDX_NONE) ? 9'h000 : (9'h001 << idx_c);
    accept_c      = set && (game_state == GS_PLAY) && ((sel_c & ~valid) != 9'h000);
    next_valid_c  = valid | (accept_c ? sel_c : 9'h000);
    next_symbol_c = symbol | ((accept_c && turn == SYM_X) ? sel_c : 9'h000);
    won_c         = 1'b0;
    for (int l = 0; l < int'(LINES); l++) begin
      if (next_valid_c[WIN_LINE[l][0]] && next_valid_c[WIN_LINE[l][1]] &&
          next_valid_c[WIN_LINE[l][2]] &&
          next_symbol_c[WIN_LINE[l][0]] == next_symbol_c[WIN_LINE[l][1]] &&
          next_symbol_c[WIN_LINE[l][1]] == next_symbol_c[WIN_LINE[l][2]]) begin
        won_c = 1'b1;
      end
    end
    if (won_c)              eval_c = (turn == SYM_X) ? GS_XWIN : GS_OWIN;
    else if (&next_valid_c) eval_c = GS_DRAW;
    else                    eval_c = GS_PLAY;
  end

  // Board storage; only the selected cell sees a set, and only on an accepted move.
  for (genvar i = 0; i < int'(CELLS); i++) begin : g_cell
    ttt_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .set        (accept_c && sel_c[i]),
      .set_symbol (turn),
      .valid      (valid[i]),
      .symbol     (symbol[i])
    );
  end

  // Game state, turn and rejection pulse; a decided game freezes turn and state.
  always_ff @(posedge clk) begin
    if (reset) begin
      game_state <= GS_PLAY;
      turn       <= X_FIRST;
      move_err   <= 1'b0;
    end else begin
      move_err <= set && !accept_c;
      if (accept_c) begin
        turn       <= ~turn;
        game_state <= eval_c;
      end
    end
  end

endmodule

// File: tb/tb_ttt_board.sv
// Self-checking bench for ttt_board: directed games plus random play against a board model.
module tb_ttt_board;

  logic       clk = 1'b0;
  logic       reset;
  logic       set;
  logic [1:0] row;
  logic [1:0] col;
  logic [8:0] valid;
  logic [8:0] symbol;
  logic [1:0] game_state;
  logic       turn;
  logic       move_err;

  int checks = 0;
  int errors = 0;

  // Model: 0 empty, 1 X, 2 O.
  int m_board [9];
  int m_turn;
  int m_gs;
  int m_err;

  ttt_board dut (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .row        (row),
    .col        (col),
    .valid      (valid),
    .symbol     (symbol),
    .game_state (game_state),
    .turn       (turn),
    .move_err   (move_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit line_won(int a, int b, int c);
    return m_board[a] != 0 && m_board[a] == m_board[b] && m_board[b] == m_board[c];
  endfunction

  function automatic bit any_win();
    bit w = 0;
    for (int k = 0; k < 3; k++) begin
      if (line_won(3*k, 3*k+1, 3*k+2)) w = 1;
      if (line_won(k, k+3, k+6))       w = 1;
    end
    if (line_won(0, 4, 8) || line_won(2, 4, 6)) w = 1;
    return w;
  endfunction

  function automatic bit board_full();
    for (int i = 0; i < 9; i++) if (m_board[i] == 0) return 0;
    return 1;
  endfunction

  task automatic model_step(input bit r, input bit s, input int rr, input int cc);
    int idx;
    int mover;
    if (r) begin
      foreach (m_board[i]) m_board[i] = 0;
      m_turn = 1; m_gs = 0; m_err = 0;
    end else if (s) begin
      idx = rr * 3 + cc;
      if (rr < 3 && cc < 3 && m_gs == 0 && m_board[idx] == 0) begin
        mover = m_turn;
        m_board[idx] = mover ? 1 : 2;
        m_turn = 1 - m_turn;
        if (any_win())        m_gs = mover ? 1 : 2;
        else if (board_full()) m_gs = 3;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      m_err = 0;
    end
  endtask

  // Drive one cycle, advance the model, then compare every output after the edge.
  task automatic step(input bit r, input bit s, input int rr, input int cc);
    logic [8:0] ev;
    logic [8:0] es;
    reset = r; set = s; row = 2'(rr); col = 2'(cc);
    @(posedge clk);
    #1;
    model_step(r, s, rr, cc);
    for (int i = 0; i < 9; i++) begin
      ev[i] = (m_board[i] != 0);
      es[i] = (m_board[i] == 1);
    end
    check("valid",      32'(valid),      32'(ev));
    check("symbol",     32'(symbol),     32'(es));
    check("game_state", 32'(game_state), 32'(m_gs));
    check("turn",       32'(turn),       32'(m_turn));
    check("move_err",   32'(move_err),   32'(m_err));
    reset = 1'b0; set = 1'b0;
  endtask

  task automatic mv(input int idx);
    step(1'b0, 1'b1, idx / 3, idx % 3);
  endtask

  initial begin
    int seq_draw [9] = '{4, 0, 2, 6, 3, 5, 1, 7, 8};
    int seq_owin [6] = '{0, 2, 1, 4, 8, 6};
    reset = 1'b1; set = 1'b0; row = 2'd0; col = 2'd0;
    foreach (m_board[i]) m_board[i] = 0;
    m_turn = 1; m_gs = 0; m_err = 0;

    // Reset and idle
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    check("tp1_valid", 32'(valid), 32'h000);
    check("tp1_turn",  32'(turn),  32'h1);

    // X wins on the top row, then a late move is rejected
    mv(0); mv(3); mv(1); mv(4); mv(2);
    check("tp2_valid",  32'(valid),      32'h01F);
    check("tp2_symbol", 32'(symbol),     32'h007);
    check("tp2_gs",     32'(game_state), 32'h1);
    mv(8);
    check("tp2_err",    32'(move_err),   32'h1);
    check("tp2_hold",   32'(valid),      32'h01F);

    // Occupied cell and illegal coordinate
    step(1'b1, 1'b0, 0, 0);
    mv(4); mv(4);
    check("tp3_occ_err", 32'(move_err), 32'h1);
    check("tp3_sym4",    32'(symbol[4]), 32'h1);
    check("tp3_turn",    32'(turn),      32'h0);
    step(1'b0, 1'b1, 3, 0);
    check("tp3_ill_err", 32'(move_err), 32'h1);
    check("tp3_ill_brd", 32'(valid),    32'h010);

    // Draw exactly on the ninth move
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      mv(seq_draw[i]);
      if (i == 7) check("tp4_gs_pre", 32'(game_state), 32'h0);
    end
    check("tp4_valid", 32'(valid),      32'h1FF);
    check("tp4_gs",    32'(game_state), 32'h3);

    // O wins on the anti-diagonal; turn frozen afterwards
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) mv(seq_owin[i]);
    check("tp5_gs",   32'(game_state), 32'h2);
    mv(3);
    check("tp5_turn", 32'(turn),       32'h1);
    check("tp5_err",  32'(move_err),   32'h1);

    // Reset with a concurrent set wins
    step(1'b1, 1'b0, 0, 0);
    mv(0); mv(1); mv(3);
    step(1'b1, 1'b1, 2, 2);
    check("tp6_valid", 32'(valid), 32'h000);
    check("tp6_turn",  32'(turn),  32'h1);
    mv(8);
    check("tp6_valid2",  32'(valid),  32'h100);
    check("tp6_symbol2", 32'(symbol), 32'h100);

    // Random play with occasional resets
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
